// File: rtl/sse_mode_select_pkg.sv
// -----------------------------------------------------------------------------
// mode_select_pkg
// Shared definitions for the SSE-based mode selector (sse_mode_select).
//   - state_e        : controller states (IDLE / COLLECT / FLUSH)
//   - COST_MAX       : all-ones cost at the default cost width, used as the
//                      "nothing seen yet" running minimum
//   - *_DEF          : default NUM_MODES / MODE_W / COST_W for the top
// Optional feature macro used by the block: SSE_MODE_SELECT_RD_COST_EN
// -----------------------------------------------------------------------------
package mode_select_pkg;

  localparam int NUM_MODES_DEF = 10;
  localparam int MODE_W_DEF    = 4;
  localparam int COST_W_DEF    = 32;

  localparam logic [COST_W_DEF-1:0] COST_MAX = '1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    FLUSH   = 2'd2
  } state_e;

endpackage

// File: rtl/sse_mode_select_cost_calc.sv
// -----------------------------------------------------------------------------
// sse_cost_calc
// First pipeline stage of the mode selector: turns one candidate's SSE into a
// cost and registers it together with its mode index and a valid flag.
//   SSE_MODE_SELECT_RD_COST_EN defined : cost = sse_in + lambda_in*bits_in,
//                                        saturating at all-ones
//   not defined                        : cost = sse_in
// Ports
//   clk, rst_n        clock / asynchronous active-low reset
//   in_valid          sample accepted this cycle (already qualified by the top)
//   idx_in            mode index of the sample
//   sse_in            SSE of the sample
//   bits_in           header bits of the sample
//   lambda_in         rate weight held for the current search
//   cost_q/idx_q/v_q  registered cost, index and valid
// -----------------------------------------------------------------------------
module sse_cost_calc #(
  parameter int MODE_W = 4,
  parameter int COST_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [MODE_W-1:0] idx_in,
  input  logic [COST_W-1:0] sse_in,
  input  logic [7:0]        bits_in,
  input  logic [15:0]       lambda_in,
  output logic [COST_W-1:0] cost_q,
  output logic [MODE_W-1:0] idx_q,
  output logic              v_q
);

  logic [COST_W-1:0] cost_d;
  logic [MODE_W-1:0] idx_d;
  logic              v_d;

`ifdef SSE_MODE_SELECT_RD_COST_EN
  logic [23:0]       rate;
  logic [COST_W:0]   sum;

  always_comb begin
    rate   = {8'd0, lambda_in} * {16'd0, bits_in};
    // One extra bit catches the carry out so we can clamp instead of wrapping.
    sum    = {1'b0, sse_in} + (COST_W+1)'(rate);
    cost_d = sum[COST_W] ? '1 : sum[COST_W-1:0];
  end
`else
  logic unused_rate;
  assign unused_rate = ^{bits_in, lambda_in};

  always_comb begin
    cost_d = sse_in;
  end
`endif

  always_comb begin
    idx_d = idx_in;
    v_d   = in_valid;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cost_q <= '0;
      idx_q  <= '0;
      v_q    <= 1'b0;
    end else begin
      cost_q <= cost_d;
      idx_q  <= idx_d;
      v_q    <= v_d;
    end
  end

endmodule

// File: rtl/sse_mode_select.sv
// -----------------------------------------------------------------------------
// sse_mode_select
// Collects one SSE per candidate mode (modes arrive in order 0..NUM_MODES-1),
// turns each into a cost, tracks the running minimum and reports the winner.
// Pipeline: S1 (sse_cost_calc) registers cost/index/valid, S2 compares against
// the running minimum. With the last sample in cycle T, best_mode/best_cost
// load at the end of cycle T+1 and done is high during cycle T+2.
// Optional feature macro: SSE_MODE_SELECT_RD_COST_EN (rate-weighted cost;
// lambda is captured on start). Without it lambda and bits_in are ignored.
// Ports
//   clk, rst_n   clock / asynchronous active-low reset
//   start        1-cycle pulse, (re)starts a search from any state
//   sse_in       SSE of current candidate;  sse_valid qualifies sse_in/bits_in
//   lambda       rate weight (sampled on start)
//   bits_in      header bits of current candidate
//   busy         search in progress
//   best_mode    index of the minimum-cost candidate (holds until next done)
//   best_cost    cost of best_mode (holds until next done)
//   done         1-cycle pulse when best_mode/best_cost are fresh
// -----------------------------------------------------------------------------
module sse_mode_select
  import mode_select_pkg::*;
#(
  parameter int NUM_MODES = NUM_MODES_DEF,
  parameter int MODE_W    = MODE_W_DEF,
  parameter int COST_W    = COST_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [COST_W-1:0] sse_in,
  input  logic              sse_valid,
  input  logic [15:0]       lambda,
  input  logic [7:0]        bits_in,
  output logic              busy,
  output logic [MODE_W-1:0] best_mode,
  output logic [COST_W-1:0] best_cost,
  output logic              done
);

  localparam logic [MODE_W-1:0] LAST_IDX = MODE_W'(NUM_MODES - 1);

  state_e            state_q, state_d;
  logic [MODE_W-1:0] count_q, count_d;
  logic [COST_W-1:0] run_min_q, run_min_d;
  logic [MODE_W-1:0] run_idx_q, run_idx_d;
  logic [MODE_W-1:0] best_mode_q, best_mode_d;
  logic [COST_W-1:0] best_cost_q, best_cost_d;
  logic              done_q, done_d;
  logic              accept;

  logic [COST_W-1:0] cost_q;
  logic [MODE_W-1:0] idx_q;
  logic              v_q;

  logic [15:0]       lambda_q;

`ifdef SSE_MODE_SELECT_RD_COST_EN
  logic [15:0] lambda_d;

  always_comb begin
    lambda_d = start ? lambda : lambda_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lambda_q <= '0;
    end else begin
      lambda_q <= lambda_d;
    end
  end
`else
  logic unused_lambda;
  assign unused_lambda = ^lambda;
  assign lambda_q      = '0;
`endif

  // A sample is taken only while collecting; a coincident start wins.
  assign accept = (state_q == COLLECT) && sse_valid && !start;

  sse_cost_calc #(
    .MODE_W (MODE_W),
    .COST_W (COST_W)
  ) u_cost_calc (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (accept),
    .idx_in    (count_q),
    .sse_in    (sse_in),
    .bits_in   (bits_in),
    .lambda_in (lambda_q),
    .cost_q    (cost_q),
    .idx_q     (idx_q),
    .v_q       (v_q)
  );

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    run_min_d   = run_min_q;
    run_idx_d   = run_idx_q;
    best_mode_d = best_mode_q;
    best_cost_d = best_cost_q;
    done_d      = 1'b0;

    // S2: strict compare, so on a tie the earlier (lower) index is kept.
    if (v_q && (cost_q < run_min_q)) begin
      run_min_d = cost_q;
      run_idx_d = idx_q;
    end

    unique case (state_q)
      IDLE: ;
      COLLECT: begin
        if (accept) begin
          if (count_q == LAST_IDX) begin
            state_d = FLUSH;
          end else begin
            count_d = count_q + 1'b1;
          end
        end
      end
      FLUSH: begin
        // Stay through the done cycle so busy covers it, then go idle.
        if (done_q) begin
          state_d = IDLE;
        end else if (v_q) begin
          // The only sample in S1 during FLUSH is the last candidate; the
          // result uses the minimum already updated with it.
          done_d      = 1'b1;
          best_mode_d = run_idx_d;
          best_cost_d = run_min_d;
        end
      end
      default: state_d = IDLE;
    endcase

    // Restart from any state; a sample still in S1 is abandoned.
    if (start) begin
      state_d     = COLLECT;
      count_d     = '0;
      run_min_d   = '1;
      run_idx_d   = '0;
      best_mode_d = best_mode_q;
      best_cost_d = best_cost_q;
      done_d      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      count_q     <= '0;
      run_min_q   <= '1;
      run_idx_q   <= '0;
      best_mode_q <= '0;
      best_cost_q <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      run_min_q   <= run_min_d;
      run_idx_q   <= run_idx_d;
      best_mode_q <= best_mode_d;
      best_cost_q <= best_cost_d;
      done_q      <= done_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign best_mode = best_mode_q;
  assign best_cost = best_cost_q;
  assign done      = done_q;

endmodule

// File: tb/tb_sse_mode_select.sv
// -----------------------------------------------------------------------------
// tb_sse_mode_select
// Self-checking bench for sse_mode_select (NUM_MODES=4, MODE_W=2, COST_W=32).
// A search-level model (list of collected costs, first index of the minimum)
// predicts busy/done/best_mode/best_cost every cycle; directed searches pin
// the model with hand-computed results, then random traffic runs.
// Honours SSE_MODE_SELECT_RD_COST_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_sse_mode_select;

  localparam int NM = 4;
  localparam int MW = 2;
  localparam int CW = 32;
`ifdef SSE_MODE_SELECT_RD_COST_EN
  localparam bit RD = 1'b1;
`else
  localparam bit RD = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [CW-1:0] sse_in = '0;
  logic          sse_valid = 1'b0;
  logic [15:0]   lambda = '0;
  logic [7:0]    bits_in = '0;
  logic          busy;
  logic [MW-1:0] best_mode;
  logic [CW-1:0] best_cost;
  logic          done;

  sse_mode_select #(
    .NUM_MODES (NM),
    .MODE_W    (MW),
    .COST_W    (CW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .sse_in    (sse_in),
    .sse_valid (sse_valid),
    .lambda    (lambda),
    .bits_in   (bits_in),
    .busy      (busy),
    .best_mode (best_mode),
    .best_cost (best_cost),
    .done      (done)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int done_count = 0;
  bit chk_en = 1'b0;

  // ---------------- behavioural model ----------------
  // phase: 0 idle, 1 collecting, 2 all candidates in (result next), 3 done cycle
  int            phase;
  logic [CW-1:0] q[$];
  logic [15:0]   m_lambda;
  logic          exp_busy, exp_done;
  logic [MW-1:0] exp_mode;
  logic [CW-1:0] exp_cost;

  function automatic logic [CW-1:0] model_cost(logic [CW-1:0] s, logic [7:0] b, logic [15:0] l);
    longint unsigned t;
    t = longint'(s) + longint'(l) * longint'(b);
    if (!RD) return s;
    return (t > 64'h0000_0000_FFFF_FFFF) ? 32'hFFFF_FFFF : t[31:0];
  endfunction

  task automatic model_reset();
    phase    = 0;
    q.delete();
    m_lambda = '0;
    exp_busy = 1'b0;
    exp_done = 1'b0;
    exp_mode = '0;
    exp_cost = '0;
  endtask

  task automatic model_step(logic st, logic v, logic [CW-1:0] s, logic [7:0] b, logic [15:0] l);
    int bi;
    exp_done = 1'b0;
    if (st) begin
      q.delete();
      m_lambda = l;
      phase = 1;
    end else begin
      case (phase)
        1: if (v) begin
          q.push_back(model_cost(s, b, m_lambda));
          if (q.size() == NM) phase = 2;
        end
        2: begin
          bi = 0;
          for (int i = 1; i < q.size(); i++) if (q[i] < q[bi]) bi = i;
          exp_mode = MW'(bi);
          exp_cost = q[bi];
          exp_done = 1'b1;
          phase = 3;
        end
        3: phase = 0;
        default: ;
      endcase
    end
    exp_busy = (phase != 0);
  endtask

  // ---------------- comparison ----------------
  task automatic cmp(string name, logic [CW-1:0] act, logic [CW-1:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h required 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("busy", 32'(busy), 32'(exp_busy));
      cmp("done", 32'(done), 32'(exp_done));
      cmp("best_mode", 32'(best_mode), 32'(exp_mode));
      cmp("best_cost", best_cost, exp_cost);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(logic st, logic v, logic [CW-1:0] s, logic [7:0] b, logic [15:0] l);
    @(negedge clk);
    start = st; sse_valid = v; sse_in = s; bits_in = b; lambda = l;
    @(posedge clk);
    #1;
    if (rst_n) model_step(st, v, s, b, l);
    if (done === 1'b1) done_count++;
  endtask

  // Returns the cycle offset of done relative to the last valid (-1 if none).
  task automatic run_search(logic [CW-1:0] s[NM], logic [7:0] b[NM], logic [15:0] l, output int lat);
    step(1'b1, 1'b0, '0, '0, l);
    for (int i = 0; i < NM; i++) step(1'b0, 1'b1, s[i], b[i], 16'd0);
    lat = -1;
    for (int k = 1; k <= 6; k++) begin
      step(1'b0, 1'b0, '0, '0, 16'd0);
      if (done === 1'b1 && lat < 0) lat = k + 1;
    end
    if (lat < 0) $display("FAIL search_timeout: got no done required done within 7 cycles");
  endtask

  task automatic async_reset();
    @(negedge clk);
    start = 1'b0; sse_valid = 1'b0;
    #2 rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int lat, d0;
    logic [CW-1:0] s[NM];
    logic [7:0]    b[NM];

    model_reset();
    repeat (3) @(negedge clk);
    rst_n  = 1'b1;
    chk_en = 1'b1;
    cmp("reset_busy", 32'(busy), 32'd0);
    cmp("reset_done", 32'(done), 32'd0);
    cmp("reset_mode", 32'(best_mode), 32'd0);
    cmp("reset_cost", best_cost, 32'd0);

    // T1: tie on 50 keeps the lower index
    s = '{32'd100, 32'd50, 32'd75, 32'd50};
    b = '{8'd0, 8'd0, 8'd0, 8'd0};
    run_search(s, b, 16'd0, lat);
    cmp("t1_latency", 32'(lat), 32'd2);
    cmp("t1_mode", 32'(best_mode), 32'd1);
    cmp("t1_cost", best_cost, 32'd50);
    cmp("t1_model_cost", exp_cost, 32'd50);

    // T2: rate term changes the winner when enabled
    s = '{32'd100, 32'd50, 32'd75, 32'd90};
    b = '{8'd1, 8'd20, 8'd2, 8'd3};
    run_search(s, b, 16'd4, lat);
    cmp("t2_latency", 32'(lat), 32'd2);
    cmp("t2_mode", 32'(best_mode), RD ? 32'd2 : 32'd1);
    cmp("t2_cost", best_cost, RD ? 32'd83 : 32'd50);
    cmp("t2_model_mode", 32'(exp_mode), RD ? 32'd2 : 32'd1);

    // T3: saturation and all-ones ties
    s = '{32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    b = '{8'hFF, 8'd0, 8'd0, 8'd0};
    run_search(s, b, 16'hFFFF, lat);
    cmp("t3_mode", 32'(best_mode), 32'd0);
    cmp("t3_cost", best_cost, RD ? 32'hFFFF_FFFF : 32'hFFFF_FFF0);
    cmp("t3_model_cost", exp_cost, RD ? 32'hFFFF_FFFF : 32'hFFFF_FFF0);

    // T4: restart after two samples, then a full fresh search
    d0 = done_count;
    step(1'b1, 1'b0, '0, '0, 16'd0);
    step(1'b0, 1'b1, 32'd1, '0, 16'd0);
    step(1'b0, 1'b1, 32'd2, '0, 16'd0);
    s = '{32'd9, 32'd8, 32'd7, 32'd6};
    b = '{8'd0, 8'd0, 8'd0, 8'd0};
    run_search(s, b, 16'd0, lat);
    cmp("t4_done_pulses", 32'(done_count - d0), 32'd1);
    cmp("t4_mode", 32'(best_mode), 32'd3);
    cmp("t4_cost", best_cost, 32'd6);

    // T5: valids in IDLE, start+valid together, valid during FLUSH
    d0 = done_count;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 32'd0, '0, 16'd0);
    cmp("t5_idle_busy", 32'(busy), 32'd0);
    step(1'b1, 1'b1, 32'd1, '0, 16'd0);
    step(1'b0, 1'b1, 32'd5, '0, 16'd0);
    step(1'b0, 1'b1, 32'd3, '0, 16'd0);
    step(1'b0, 1'b1, 32'd4, '0, 16'd0);
    step(1'b0, 1'b1, 32'd2, '0, 16'd0);
    step(1'b0, 1'b1, 32'd0, '0, 16'd0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, '0, '0, 16'd0);
    cmp("t5_done_pulses", 32'(done_count - d0), 32'd1);
    cmp("t5_mode", 32'(best_mode), 32'd3);
    cmp("t5_cost", best_cost, 32'd2);

    // T6: asynchronous reset mid-collect
    step(1'b1, 1'b0, '0, '0, 16'd0);
    step(1'b0, 1'b1, 32'd1, '0, 16'd0);
    step(1'b0, 1'b1, 32'd2, '0, 16'd0);
    async_reset();
    cmp("t6_busy", 32'(busy), 32'd0);
    cmp("t6_done", 32'(done), 32'd0);
    cmp("t6_mode", 32'(best_mode), 32'd0);
    cmp("t6_cost", best_cost, 32'd0);
    s = '{32'd7, 32'd7, 32'd7, 32'd7};
    b = '{8'd0, 8'd0, 8'd0, 8'd0};
    run_search(s, b, 16'd0, lat);
    cmp("t6_latency", 32'(lat), 32'd2);
    cmp("t6_mode", 32'(best_mode), 32'd0);
    cmp("t6_cost", best_cost, 32'd7);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      logic st, v;
      logic [CW-1:0] rs;
      if ($urandom_range(0, 499) == 0) begin
        async_reset();
      end else begin
        st = exp_busy ? ($urandom_range(0, 99) < 5) : ($urandom_range(0, 99) < 30);
        v  = ($urandom_range(0, 99) < 65);
        case ($urandom_range(0, 3))
          0: rs = CW'($urandom_range(0, 15));
          1: rs = $urandom;
          2: rs = 32'hFFFF_FF00 | CW'($urandom_range(0, 255));
          default: rs = 32'd1000 + CW'($urandom_range(0, 7));
        endcase
        step(st, v, rs, 8'($urandom), 16'($urandom));
      end
    end

    step(1'b0, 1'b0, '0, '0, 16'd0);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
